// File: rtl/rv_div_seq.sv
// rv_div_seq: iterative RV32M DIV/DIVU/REM/REMU unit (radix-2 restoring, one bit per cycle).
// Define RV_DIV_REUSE_EN to keep the last computed operand pair and answer a repeat in one cycle.
module rv_div_seq #(
  parameter int unsigned ITER_BITS = 5
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_flush,
  input  logic        i_hold,
  input  logic        i_start,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  output logic        o_stall,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_result
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e               state_q, state_d;
  logic [ITER_BITS-1:0] cnt_q, cnt_d;
  logic [31:0]          rem_q, rem_d;
  logic [31:0]          quo_q, quo_d;
  logic [31:0]          dvs_q, dvs_d;
  logic [31:0]          result_q, result_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 sel_rem_q, sel_rem_d;

  logic        is_signed, div_zero, overflow;
  logic [31:0] mag1, mag2;
  logic [32:0] shifted, trial;
  logic [31:0] step_rem, step_quo, fin_quo, fin_rem;
  logic        reuse_hit;
  logic [31:0] reuse_res;
  logic        unused_funct3;

  // funct3[2] only distinguishes M-extension ops upstream; i_start already qualifies it.
  assign unused_funct3 = i_funct3[2];

  assign is_signed = ~i_funct3[0];
  assign mag1      = (is_signed && i_op1[31]) ? (~i_op1 + 32'd1) : i_op1;
  assign mag2      = (is_signed && i_op2[31]) ? (~i_op2 + 32'd1) : i_op2;
  assign div_zero  = (i_op2 == '0);
  assign overflow  = is_signed && (i_op1 == 32'h8000_0000) && (i_op2 == 32'hFFFF_FFFF);

  // The stored remainder is always below the divisor, so 32 bits hold it; the trial is 33 bits.
  assign shifted  = {rem_q, quo_q[31]};
  assign trial    = shifted - {1'b0, dvs_q};
  assign step_rem = trial[32] ? shifted[31:0] : trial[31:0];
  assign step_quo = {quo_q[30:0], ~trial[32]};
  assign fin_quo  = neg_quo_q ? (~step_quo + 32'd1) : step_quo;
  assign fin_rem  = neg_rem_q ? (~step_rem + 32'd1) : step_rem;

`ifdef RV_DIV_REUSE_EN
  logic        rc_vld_q, rc_vld_d;
  logic        rc_uns_q, rc_uns_d;
  logic [31:0] rc_op1_q, rc_op1_d, rc_op2_q, rc_op2_d;
  logic [31:0] rc_quo_q, rc_quo_d, rc_rem_q, rc_rem_d;
  logic        lat_uns_q, lat_uns_d;
  logic [31:0] lat_op1_q, lat_op1_d, lat_op2_q, lat_op2_d;

  assign reuse_hit = rc_vld_q && (i_op1 == rc_op1_q) && (i_op2 == rc_op2_q)
                     && (i_funct3[0] == rc_uns_q);
  assign reuse_res = i_funct3[1] ? rc_rem_q : rc_quo_q;
`else
  assign reuse_hit = 1'b0;
  assign reuse_res = '0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    sel_rem_d = sel_rem_q;
    o_stall   = 1'b0;
`ifdef RV_DIV_REUSE_EN
    rc_vld_d  = rc_vld_q;
    rc_uns_d  = rc_uns_q;
    rc_op1_d  = rc_op1_q;
    rc_op2_d  = rc_op2_q;
    rc_quo_d  = rc_quo_q;
    rc_rem_d  = rc_rem_q;
    lat_uns_d = lat_uns_q;
    lat_op1_d = lat_op1_q;
    lat_op2_d = lat_op2_q;
`endif
    unique case (state_q)
      StIdle: begin
        o_stall = i_start;
        if (i_start && !i_flush) begin
          sel_rem_d = i_funct3[1];
          neg_quo_d = is_signed & (i_op1[31] ^ i_op2[31]);
          neg_rem_d = is_signed & i_op1[31];
          if (div_zero) begin
            result_d = i_funct3[1] ? i_op1 : 32'hFFFF_FFFF;
            state_d  = StDone;
          end else if (overflow) begin
            result_d = i_funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
            state_d  = StDone;
          end else if (reuse_hit) begin
            result_d = reuse_res;
            state_d  = StDone;
          end else begin
            rem_d   = '0;
            quo_d   = mag1;
            dvs_d   = mag2;
            cnt_d   = '1;
            state_d = StCalc;
`ifdef RV_DIV_REUSE_EN
            lat_uns_d = i_funct3[0];
            lat_op1_d = i_op1;
            lat_op2_d = i_op2;
`endif
          end
        end
      end
      StCalc: begin
        o_stall = 1'b1;
        rem_d   = step_rem;
        quo_d   = step_quo;
        cnt_d   = cnt_q - ITER_BITS'(1);
        if (cnt_q == '0 && !i_flush) begin
          result_d = sel_rem_q ? fin_rem : fin_quo;
          state_d  = StDone;
`ifdef RV_DIV_REUSE_EN
          rc_vld_d = 1'b1;
          rc_uns_d = lat_uns_q;
          rc_op1_d = lat_op1_q;
          rc_op2_d = lat_op2_q;
          rc_quo_d = fin_quo;
          rc_rem_d = fin_rem;
`endif
        end
`ifdef RV_DIV_REUSE_EN
        if (i_flush) rc_vld_d = 1'b0;
`endif
      end
      StDone: begin
        if (!i_hold) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (i_flush) state_d = StIdle;
  end

  assign o_busy   = (state_q != StIdle);
  assign o_valid  = (state_q == StDone);
  assign o_result = result_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      sel_rem_q <= sel_rem_d;
    end
  end

`ifdef RV_DIV_REUSE_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rc_vld_q  <= 1'b0;
      rc_uns_q  <= 1'b0;
      rc_op1_q  <= '0;
      rc_op2_q  <= '0;
      rc_quo_q  <= '0;
      rc_rem_q  <= '0;
      lat_uns_q <= 1'b0;
      lat_op1_q <= '0;
      lat_op2_q <= '0;
    end else begin
      rc_vld_q  <= rc_vld_d;
      rc_uns_q  <= rc_uns_d;
      rc_op1_q  <= rc_op1_d;
      rc_op2_q  <= rc_op2_d;
      rc_quo_q  <= rc_quo_d;
      rc_rem_q  <= rc_rem_d;
      lat_uns_q <= lat_uns_d;
      lat_op1_q <= lat_op1_d;
      lat_op2_q <= lat_op2_d;
    end
  end
`endif

endmodule

// File: tb/tb_rv_div_seq.sv
// Scoreboarded random + directed bench for rv_div_seq; the reference model uses 64-bit arithmetic.
`timescale 1ns/1ps
module tb_rv_div_seq;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        hold  = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  f3    = 3'b000;
  logic [31:0] op1   = '0;
  logic [31:0] op2   = '0;
  logic        stall, busy, valid;
  logic [31:0] result;

  rv_div_seq #(.ITER_BITS(5)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_flush   (flush),
    .i_hold    (hold),
    .i_start   (start),
    .i_funct3  (f3),
    .i_op1     (op1),
    .i_op2     (op2),
    .o_stall   (stall),
    .o_busy    (busy),
    .o_valid   (valid),
    .o_result  (result)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] exp_res_q[$];
  int unsigned exp_cyc_q[$];
  string       exp_nm_q[$];

`ifdef RV_DIV_REUSE_EN
  bit          last_vld = 1'b0;
  logic [31:0] last_a, last_b;
  logic        last_uns;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return f[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic int unsigned exp_latency(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
    if (is_special(f, a, b)) return 1;
`ifdef RV_DIV_REUSE_EN
    if (last_vld && a == last_a && b == last_b && f[0] == last_uns) return 1;
`endif
    return 33;
  endfunction

  // Monitor: every consumed result (valid with no hold) is matched against the scoreboard.
  logic [31:0] mon_res;
  int unsigned mon_cyc;
  string       mon_nm;
  always @(negedge clk) begin
    if (rst_n && valid && !hold) begin
      if (exp_res_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: actual result %h, required no valid", result);
      end else begin
        mon_res = exp_res_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        mon_nm  = exp_nm_q.pop_front();
        check(mon_nm, result, mon_res);
        check({mon_nm, "_cycle"}, cyc, mon_cyc);
      end
    end
  end

  task automatic do_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input int unsigned hold_cycles);
    int unsigned lat, s, waited;
    bit got;
    lat = exp_latency(f, a, b);
    @(posedge clk); #1;
    start = 1'b1; f3 = f; op1 = a; op2 = b;
    hold  = (hold_cycles != 0);
    s = cyc;
    exp_res_q.push_back(exp);
    exp_cyc_q.push_back(s + lat + hold_cycles);
    exp_nm_q.push_back(nm);
    got = 1'b0;
    waited = 0;
    while (!got && waited < 40) begin
      @(negedge clk);
      if (valid) got = 1'b1;
      else begin
        check({nm, "_stall"}, {31'd0, stall}, 32'd1);
        waited++;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: actual no valid in 40 cycles, required valid", nm);
      exp_res_q.delete(); exp_cyc_q.delete(); exp_nm_q.delete();
      start = 1'b0; hold = 1'b0;
      return;
    end
    check({nm, "_stall_done"}, {31'd0, stall}, 32'd0);
    for (int i = 0; i < int'(hold_cycles); i++) begin
      if (i != 0) @(negedge clk);
      check({nm, "_held_valid"}, {31'd0, valid}, 32'd1);
      check({nm, "_held_result"}, result, exp);
      @(posedge clk); #1;
    end
    hold = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
`ifdef RV_DIV_REUSE_EN
    if (lat == 33) begin
      last_vld = 1'b1; last_a = a; last_b = b; last_uns = f[0];
    end
`endif
  endtask

  task automatic flush_op(input logic [31:0] a, input logic [31:0] b, input int unsigned at);
    @(posedge clk); #1;
    start = 1'b1; f3 = 3'b101; op1 = a; op2 = b;
    repeat (at) @(posedge clk);
    #1;
    flush = 1'b1; start = 1'b0;
    @(negedge clk);
    check("flush_busy_before", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("flush_busy_after", {31'd0, busy}, 32'd0);
      check("flush_no_valid", {31'd0, valid}, 32'd0);
    end
`ifdef RV_DIV_REUSE_EN
    last_vld = 1'b0;
`endif
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_stall"}, {31'd0, stall}, 32'd0);
    check({nm, "_busy"}, {31'd0, busy}, 32'd0);
    check({nm, "_valid"}, {31'd0, valid}, 32'd0);
    check({nm, "_result"}, result, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb, pa, pb;
    int unsigned mode, rh;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 0);
    do_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 0);
    do_op("div_m100_7", 3'b100, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 0);
    do_op("rem_m100_7", 3'b110, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 0);
    do_op("div_5_0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    do_op("remu_5_0", 3'b111, 32'd5, 32'd0, 32'd5, 0);
    do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    flush_op(32'd1000, 32'd7, 10);
    do_op("divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3, 0);
    do_op("div_1000_33_hold", 3'b100, 32'd1000, 32'd33, 32'd30, 3);
    do_op("rem_1000_33", 3'b110, 32'd1000, 32'd33, 32'd10, 0);

    pa = 32'd1000; pb = 32'd33;
    for (int n = 0; n < 40; n++) begin
      rf   = 3'b100 | 3'($urandom_range(0, 3));
      mode = $urandom_range(0, 7);
      ra   = $urandom;
      rb   = $urandom;
      unique case (mode)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = pa; rb = pb; end
        3: rb = 32'($urandom_range(1, 16));
        4: rb = {{16{rb[15]}}, rb[15:0]};
        default: ;
      endcase
      rh = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      do_op("rand", rf, ra, rb, ref_div(rf, ra, rb), rh);
      pa = ra; pb = rb;
    end

    @(posedge clk); #1;
    start = 1'b1; f3 = 3'b100; op1 = 32'd12345; op2 = 32'd7;
    repeat (5) @(posedge clk);
    #3;
    start = 1'b0; rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
`ifdef RV_DIV_REUSE_EN
    last_vld = 1'b0;
`endif
    do_op("divu_after_reset", 3'b101, 32'd50, 32'd5, 32'd10, 0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_res_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
